mem_port_arbiter: RTL and testbench

//  Shares the single 32-bit memory port between instruction fetch (IF) and data memory (DM) requesters.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 32-bit memory port between fetch (IF) and data (DM) requesters
module mem_port_arbiter #(
  parameter bit DM_PRIORITY = 1'b0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  addr_sel,
  output logic        mem_err
);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state_q, state_d;
  logic          last_dm_q, last_dm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    addr_sel_q, addr_sel_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          mem_err_q, mem_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  logic elig_if, elig_dm, grant_if, grant_dm, timed_out;

  // A requester being acked this cycle still shows its old req, so it sits out.
  assign elig_if   = if_req & ~if_ack_q;
  assign elig_dm   = dm_req & ~dm_ack_q;
  assign grant_dm  = elig_dm & (~elig_if | DM_PRIORITY | ~last_dm_q);
  assign grant_if  = elig_if & ~grant_dm;
  assign timed_out = (TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_sel_q  <= 2'b00;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_sel_q  <= addr_sel_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      mem_err_q   <= mem_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_sel_d  = addr_sel_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_err_d   = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = BUSY_IF;
          last_dm_d   = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          addr_sel_d  = 2'b00;
        end else if (grant_dm) begin
          state_d     = BUSY_DM;
          last_dm_d   = 1'b1;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          addr_sel_d  = 2'b01;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack || timed_out) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_err_d = ~mem_ack;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_sel  = addr_sel_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter: unit 0 round-robin/timeout 4, unit 1 DM priority/timeout 16
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], if_req[2], dm_req[2], dm_we[2], mem_ack[2];
  logic [31:0] if_addr[2], dm_addr[2], dm_wdata[2], mem_rdata[2];
  logic        if_ack_o[2], dm_ack_o[2], mem_req_o[2], mem_we_o[2], mem_err_o[2];
  logic [31:0] if_rdata_o[2], dm_rdata_o[2], mem_addr_o[2], mem_wdata_o[2];
  logic [1:0]  addr_sel_o[2];

  mem_port_arbiter #(.DM_PRIORITY(1'b0), .TIMEOUT_CYC(4)) u0 (
    .clk(clk), .rst(rst[0]), .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_rdata(if_rdata_o[0]), .if_ack(if_ack_o[0]), .dm_req(dm_req[0]), .dm_we(dm_we[0]),
    .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata_o[0]), .dm_ack(dm_ack_o[0]),
    .mem_req(mem_req_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]),
    .addr_sel(addr_sel_o[0]), .mem_err(mem_err_o[0])
  );

  mem_port_arbiter #(.DM_PRIORITY(1'b1), .TIMEOUT_CYC(16)) u1 (
    .clk(clk), .rst(rst[1]), .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_rdata(if_rdata_o[1]), .if_ack(if_ack_o[1]), .dm_req(dm_req[1]), .dm_we(dm_we[1]),
    .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata_o[1]), .dm_ack(dm_ack_o[1]),
    .mem_req(mem_req_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]),
    .addr_sel(addr_sel_o[1]), .mem_err(mem_err_o[1])
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  tmo[2]  = '{4, 16};
  bit  prio[2] = '{1'b0, 1'b1};

  // Reference model: who owns the port (0 none, 1 IF, 2 DM), last winner, cycles spent waiting.
  int          own[2], last_w[2], wait_n[2];
  logic        e_mreq[2], e_we[2], e_ifack[2], e_dmack[2], e_err[2];
  logic [1:0]  e_sel[2];
  logic [31:0] e_addr[2], e_wd[2], e_ifrd[2], e_dmrd[2];
  int          rcnt[2], rdly[2];

  function automatic logic [159:0] obs_vec(input int k);
    return {25'b0, mem_req_o[k], mem_we_o[k], addr_sel_o[k], if_ack_o[k], dm_ack_o[k],
            mem_err_o[k], mem_addr_o[k], mem_wdata_o[k], if_rdata_o[k], dm_rdata_o[k]};
  endfunction

  function automatic logic [159:0] exp_vec(input int k);
    return {25'b0, e_mreq[k], e_we[k], e_sel[k], e_ifack[k], e_dmack[k],
            e_err[k], e_addr[k], e_wd[k], e_ifrd[k], e_dmrd[k]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    logic        nif, ndm, nerr, done, eif, edm;
    logic [31:0] nifrd, ndmrd;
    int          g;
    if (rst[k]) begin
      own[k] = 0; last_w[k] = 2; wait_n[k] = 0;
      e_mreq[k] = 0; e_we[k] = 0; e_sel[k] = 2'b00; e_addr[k] = 0; e_wd[k] = 0;
      e_ifack[k] = 0; e_dmack[k] = 0; e_err[k] = 0; e_ifrd[k] = 0; e_dmrd[k] = 0;
      return;
    end
    nif = 0; ndm = 0; nerr = 0; done = 0; nifrd = 0; ndmrd = 0; g = 0;
    if (own[k] != 0) begin
      if (mem_ack[k]) done = 1'b1;
      else if (tmo[k] > 0 && wait_n[k] >= tmo[k]) begin done = 1'b1; nerr = 1'b1; end
      else if (wait_n[k] < tmo[k]) wait_n[k]++;
      if (done) begin
        if (own[k] == 1) begin nif = 1'b1; nifrd = nerr ? 32'h0 : mem_rdata[k]; end
        else begin ndm = 1'b1; ndmrd = (nerr || e_we[k]) ? 32'h0 : mem_rdata[k]; end
        own[k] = 0; e_mreq[k] = 1'b0;
      end
    end else begin
      eif = if_req[k] && !e_ifack[k];
      edm = dm_req[k] && !e_dmack[k];
      if (eif && edm) g = prio[k] ? 2 : ((last_w[k] == 1) ? 2 : 1);
      else if (eif) g = 1;
      else if (edm) g = 2;
      if (g != 0) begin
        own[k] = g; last_w[k] = g; wait_n[k] = 0; e_mreq[k] = 1'b1;
        e_sel[k]  = (g == 1) ? 2'b00 : 2'b01;
        e_addr[k] = (g == 1) ? if_addr[k] : dm_addr[k];
        e_we[k]   = (g == 2) && dm_we[k];
        e_wd[k]   = (g == 2) ? dm_wdata[k] : 32'h0;
      end
    end
    e_ifack[k] = nif; e_dmack[k] = ndm; e_err[k] = nerr; e_ifrd[k] = nifrd; e_dmrd[k] = ndmrd;
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("cyc%0d_u%0d", cyc, k), obs_vec(k), exp_vec(k));
    cyc++;
  endtask

  task automatic drive_rand(input int k);
    rst[k] = ($urandom_range(0, 99) == 0);
    if (if_ack_o[k] || !if_req[k]) begin
      if_req[k] = ($urandom_range(0, 2) != 0);
      if_addr[k] = $urandom;
    end else if ($urandom_range(0, 39) == 0) if_req[k] = 1'b0;
    if (dm_ack_o[k] || !dm_req[k]) begin
      dm_req[k] = ($urandom_range(0, 2) != 0);
      dm_we[k] = ($urandom_range(0, 1) == 1);
      dm_addr[k] = $urandom;
      dm_wdata[k] = $urandom;
    end else if ($urandom_range(0, 39) == 0) dm_req[k] = 1'b0;
    if (mem_req_o[k]) begin
      if (rcnt[k] >= rdly[k]) begin
        mem_ack[k] = 1'b1; rcnt[k] = 0;
        rdly[k] = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, 6));
      end else begin
        mem_ack[k] = 1'b0; rcnt[k]++;
      end
    end else begin
      mem_ack[k] = ($urandom_range(0, 11) == 0);
      rcnt[k] = 0;
    end
    mem_rdata[k] = $urandom;
  endtask

  int gsel[8], gidx[8];
  int ng, n;
  logic prev_req;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; if_req[k] = 0; dm_req[k] = 0; dm_we[k] = 0; mem_ack[k] = 0;
      if_addr[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0; mem_rdata[k] = 0;
    end
    tick(); tick();
    chk("reset_u0", obs_vec(0), 160'h0);
    chk("reset_u1", obs_vec(1), 160'h0);
    rst[0] = 0; rst[1] = 0;
    tick();

    // IF-only fetch, memory acks in the second mem_req cycle
    if_req[0] = 1; if_addr[0] = 32'h0040_0000;
    tick();
    chk("t1_mem_req", mem_req_o[0], 1'b1);
    chk("t1_addr", mem_addr_o[0], 32'h0040_0000);
    chk("t1_sel", addr_sel_o[0], 2'b00);
    tick();
    mem_ack[0] = 1; mem_rdata[0] = 32'h8C08_0004;
    tick();
    chk("t1_if_ack", if_ack_o[0], 1'b1);
    chk("t1_if_rdata", if_rdata_o[0], 32'h8C08_0004);
    chk("t1_we", mem_we_o[0], 1'b0);
    if_req[0] = 0; mem_ack[0] = 0;
    tick();
    chk("t1_ack_pulse", {if_ack_o[0], if_rdata_o[0]}, 33'h0);

    // store
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h1001_0000; dm_wdata[0] = 32'hDEAD_BEEF;
    tick();
    chk("t2_we", mem_we_o[0], 1'b1);
    chk("t2_wdata", mem_wdata_o[0], 32'hDEAD_BEEF);
    chk("t2_sel", addr_sel_o[0], 2'b01);
    mem_ack[0] = 1; mem_rdata[0] = 32'h1234_5678;
    tick();
    chk("t2_acks", {dm_ack_o[0], if_ack_o[0], dm_rdata_o[0]}, {2'b10, 32'h0});
    dm_req[0] = 0; dm_we[0] = 0; mem_ack[0] = 0;
    tick();

    // simultaneous requests from reset, round-robin, single-cycle memory
    rst[0] = 1; tick(); rst[0] = 0;
    if_req[0] = 1; if_addr[0] = 32'h100; dm_req[0] = 1; dm_addr[0] = 32'h200;
    ng = 0; prev_req = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ack[0] = mem_req_o[0]; mem_rdata[0] = $urandom;
      tick();
      if (mem_req_o[0] && !prev_req && ng < 8) begin
        gsel[ng] = int'(addr_sel_o[0]); gidx[ng] = i; ng++;
      end
      prev_req = mem_req_o[0];
    end
    chk("t3_grants", ng, 6);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("t3_sel%0d", i), gsel[i], i % 2);
      if (i > 0) chk($sformatf("t3_gap%0d", i), gidx[i] - gidx[i-1], 2);
    end
    if_req[0] = 0; dm_req[0] = 0; mem_ack[0] = 0;
    tick(); tick();

    // DM priority: a tie right after a DM transaction still goes to DM
    rst[1] = 1; tick(); rst[1] = 0;
    dm_req[1] = 1; dm_addr[1] = 32'h300;
    tick();
    mem_ack[1] = 1;
    tick();
    dm_req[1] = 0; mem_ack[1] = 0;
    tick();
    if_req[1] = 1; if_addr[1] = 32'h400; dm_req[1] = 1; dm_addr[1] = 32'h500;
    tick();
    chk("t4_tie_dm", {mem_req_o[1], addr_sel_o[1]}, 3'b101);
    for (int i = 0; i < 8; i++) begin
      mem_ack[1] = mem_req_o[1];
      tick();
    end
    if_req[1] = 0; dm_req[1] = 0; mem_ack[1] = 0;
    tick(); tick();

    // timeout with no mem_ack, then a stray ack in IDLE
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h600;
    tick();
    chk("t5_mem_req", mem_req_o[0], 1'b1);
    n = 0;
    while (n < 20 && !dm_ack_o[0]) begin tick(); n++; end
    chk("t5_latency", n, 5);
    chk("t5_err", {dm_ack_o[0], mem_err_o[0], mem_req_o[0], dm_rdata_o[0]}, {3'b110, 32'h0});
    dm_req[0] = 0; mem_ack[0] = 1; mem_rdata[0] = 32'hFFFF_FFFF;
    tick();
    chk("t5_stray", {mem_req_o[0], dm_ack_o[0], mem_err_o[0]}, 3'b000);
    mem_ack[0] = 0;
    tick();

    // reset one cycle into BUSY_IF
    if_req[0] = 1; if_addr[0] = 32'h700;
    tick();
    rst[0] = 1;
    tick();
    chk("t6_abort", {mem_req_o[0], addr_sel_o[0], if_ack_o[0]}, 4'b0000);
    rst[0] = 0; dm_req[0] = 1; dm_addr[0] = 32'h800;
    tick();
    chk("t6_tie_if", {mem_req_o[0], addr_sel_o[0], mem_addr_o[0]}, {3'b100, 32'h700});

    rst[0] = 1; rst[1] = 1;
    tick();
    for (int i = 0; i < 4000; i++) begin
      drive_rand(0);
      drive_rand(1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
